keypad_booth_calc: RTL and testbench



---
 rtl/keypad_booth_calc.sv | 274 +++++++++++++++++++++++++++
 tb/tb_keypad_booth_calc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_booth_calc.sv
// keypad_booth_calc
//   Keypad calculator core. Builds two signed decimal operands from debounced
//   key codes, multiplies them with a sequential radix-2 Booth engine (one
//   iteration per clock) and presents a sign/magnitude value for the
//   BCD/7-segment display path.
//
//   Ports
//     clk            system clock, rising edge
//     rst            synchronous active-high reset
//     key_valid      one-cycle strobe qualifying key_code
//     key_code[3:0]  0-9 digit, A sign, B enter A, C clear entry,
//                    D execute, E ignored, F clear all
//     a_val, b_val   signed operands (two's complement)
//     product        signed A*B, valid from done until the next clear
//     display_value  magnitude of the selected value
//     display_neg    selected value is negative and non-zero
//     busy           multiplication iterating
//     done           one-cycle pulse when product becomes valid
//     overflow       sticky flag for a rejected entry digit
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ENTER_A | keys build operand A; display shows A
//   ENTER_B | keys build operand B; display shows B
//   MULT    | Booth engine iterating; keys ignored; display B
//   SHOW    | product valid and displayed; digit starts new A

module keypad_booth_calc #(
   parameter int WIDTH      = 8,
   parameter int MAX_DIGITS = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      key_valid,
   input  logic [3:0]                key_code,
   output logic signed [WIDTH-1:0]   a_val,
   output logic signed [WIDTH-1:0]   b_val,
   output logic signed [2*WIDTH-1:0] product,
   output logic [2*WIDTH-1:0]        display_value,
   output logic                      display_neg,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow
);

   localparam int MW = WIDTH - 1;
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [MW+3:0] MAX_MAG   = {4'b0000, {MW{1'b1}}};
   localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_DIGITS);
   localparam logic [IW-1:0] LAST_ITER = IW'(WIDTH - 1);

   typedef enum logic [1:0] {ENTER_A, ENTER_B, MULT, SHOW} state_t;

   state_t              state_q, state_d;
   logic [MW-1:0]       a_mag_q, a_mag_d, b_mag_q, b_mag_d;
   logic                a_neg_q, a_neg_d, b_neg_q, b_neg_d;
   logic [CW-1:0]       a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
   logic [2*WIDTH-1:0]  prod_q, prod_d;
   logic                ovf_q, ovf_d;
   logic                done_q, done_d;
   logic [WIDTH:0]      acc_q, acc_d;
   logic [WIDTH-1:0]    mq_q, mq_d;
   logic                qm1_q, qm1_d;
   logic [IW-1:0]       iter_q, iter_d;

   logic                is_digit, a_ok, b_ok, clr_all, load_first;
   logic [MW+3:0]       a_try, b_try, first_try;
   logic [WIDTH:0]      a_ext, sum, acc_sh;
   logic [WIDTH-1:0]    mq_sh;

   // Headroom of 4 bits: mag*10+9 < 16*2^MW, so the compare never wraps.
   function automatic logic [MW+3:0] times10_plus(input logic [MW-1:0] mag,
                                                 input logic [3:0]    d);
      return ({4'b0000, mag} << 3) + ({4'b0000, mag} << 1) + {{MW{1'b0}}, d};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ENTER_A;
         a_mag_q <= '0;
         a_neg_q <= 1'b0;
         a_cnt_q <= '0;
         b_mag_q <= '0;
         b_neg_q <= 1'b0;
         b_cnt_q <= '0;
         prod_q  <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         acc_q   <= '0;
         mq_q    <= '0;
         qm1_q   <= 1'b0;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         a_mag_q <= a_mag_d;
         a_neg_q <= a_neg_d;
         a_cnt_q <= a_cnt_d;
         b_mag_q <= b_mag_d;
         b_neg_q <= b_neg_d;
         b_cnt_q <= b_cnt_d;
         prod_q  <= prod_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         qm1_q   <= qm1_d;
         iter_q  <= iter_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_mag_d    = a_mag_q;
      a_neg_d    = a_neg_q;
      a_cnt_d    = a_cnt_q;
      b_mag_d    = b_mag_q;
      b_neg_d    = b_neg_q;
      b_cnt_d    = b_cnt_q;
      prod_d     = prod_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      acc_d      = acc_q;
      mq_d       = mq_q;
      qm1_d      = qm1_q;
      iter_d     = iter_q;
      clr_all    = 1'b0;
      load_first = 1'b0;

      is_digit  = (key_code <= 4'd9);
      a_try     = times10_plus(a_mag_q, key_code);
      b_try     = times10_plus(b_mag_q, key_code);
      first_try = times10_plus('0, key_code);
      a_ok      = (a_cnt_q < MAX_CNT) && (a_try <= MAX_MAG);
      b_ok      = (b_cnt_q < MAX_CNT) && (b_try <= MAX_MAG);

      // Booth step: the extra accumulator bit absorbs the add/subtract of a
      // sign-extended A, then {acc, q, q_-1} shifts right arithmetically.
      a_ext = {a_val[WIDTH-1], a_val};
      case ({mq_q[0], qm1_q})
         2'b01:   sum = acc_q + a_ext;
         2'b10:   sum = acc_q - a_ext;
         default: sum = acc_q;
      endcase
      acc_sh = {sum[WIDTH], sum[WIDTH:1]};
      mq_sh  = {sum[0], mq_q[WIDTH-1:1]};

      case (state_q)
         ENTER_A: if (key_valid) begin
            if (is_digit) begin
               if (a_ok) begin
                  a_mag_d = a_try[MW-1:0];
                  a_cnt_d = a_cnt_q + CW'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end else begin
               case (key_code)
                  4'hA: a_neg_d = ~a_neg_q;
                  4'hB: begin
                     state_d = ENTER_B;
                     b_mag_d = '0;
                     b_neg_d = 1'b0;
                     b_cnt_d = '0;
                  end
                  4'hC: begin
                     a_mag_d = '0;
                     a_neg_d = 1'b0;
                     a_cnt_d = '0;
                     ovf_d   = 1'b0;
                  end
                  4'hF:    clr_all = 1'b1;
                  default: ;
               endcase
            end
         end
         ENTER_B: if (key_valid) begin
            if (is_digit) begin
               if (b_ok) begin
                  b_mag_d = b_try[MW-1:0];
                  b_cnt_d = b_cnt_q + CW'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end else begin
               case (key_code)
                  4'hA: b_neg_d = ~b_neg_q;
                  4'hC: begin
                     b_mag_d = '0;
                     b_neg_d = 1'b0;
                     b_cnt_d = '0;
                     ovf_d   = 1'b0;
                  end
                  4'hD: begin
                     state_d = MULT;
                     acc_d   = '0;
                     mq_d    = b_val;
                     qm1_d   = 1'b0;
                     iter_d  = LAST_ITER;
                  end
                  4'hF:    clr_all = 1'b1;
                  default: ;
               endcase
            end
         end
         MULT: begin
            acc_d = acc_sh;
            mq_d  = mq_sh;
            qm1_d = mq_q[0];
            if (iter_q == '0) begin
               prod_d  = {acc_sh[WIDTH-1:0], mq_sh};
               done_d  = 1'b1;
               state_d = SHOW;
            end else begin
               iter_d = iter_q - IW'(1);
            end
         end
         SHOW: if (key_valid) begin
            if (is_digit) begin
               clr_all    = 1'b1;
               load_first = 1'b1;
            end else if (key_code == 4'hF) begin
               clr_all = 1'b1;
            end
         end
         default: state_d = ENTER_A;
      endcase

      if (clr_all) begin
         state_d = ENTER_A;
         a_mag_d = '0;
         a_neg_d = 1'b0;
         a_cnt_d = '0;
         b_mag_d = '0;
         b_neg_d = 1'b0;
         b_cnt_d = '0;
         prod_d  = '0;
         ovf_d   = 1'b0;
      end
      // A digit in SHOW starts a fresh A with that digit.
      if (load_first) begin
         if (first_try <= MAX_MAG) begin
            a_mag_d = first_try[MW-1:0];
            a_cnt_d = CW'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_comb begin
      a_val    = a_neg_q ? -{1'b0, a_mag_q} : {1'b0, a_mag_q};
      b_val    = b_neg_q ? -{1'b0, b_mag_q} : {1'b0, b_mag_q};
      product  = prod_q;
      busy     = (state_q == MULT);
      done     = done_q;
      overflow = ovf_q;
      case (state_q)
         ENTER_A: begin
            display_value = {{(WIDTH+1){1'b0}}, a_mag_q};
            display_neg   = a_neg_q && (a_mag_q != '0);
         end
         SHOW: begin
            display_value = prod_q[2*WIDTH-1] ? -prod_q : prod_q;
            display_neg   = prod_q[2*WIDTH-1];
         end
         default: begin
            display_value = {{(WIDTH+1){1'b0}}, b_mag_q};
            display_neg   = b_neg_q && (b_mag_q != '0);
         end
      endcase
   end

endmodule

// File: tb/tb_keypad_booth_calc.sv
module tb_keypad_booth_calc;

   localparam int W      = 8;
   localparam int MAXD   = 3;
   localparam int MAXMAG = (1 << (W - 1)) - 1;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  key_valid = 1'b0;
   logic [3:0]            key_code = 4'h0;
   logic signed [W-1:0]   a_val, b_val;
   logic signed [2*W-1:0] product;
   logic [2*W-1:0]        display_value;
   logic                  display_neg, busy, done, overflow;

   keypad_booth_calc #(.WIDTH(W), .MAX_DIGITS(MAXD)) dut (
      .clk           (clk),
      .rst           (rst),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .a_val         (a_val),
      .b_val         (b_val),
      .product       (product),
      .display_value (display_value),
      .display_neg   (display_neg),
      .busy          (busy),
      .done          (done),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference model: calculator described as plain integers.
   // m_st: 0 entering A, 1 entering B, 2 multiplying, 3 showing product
   int m_st = 0;
   int a_mag = 0, b_mag = 0, a_cnt = 0, b_cnt = 0;
   bit a_neg = 0, b_neg = 0, m_ovf = 0;
   int m_prod = 0;
   int m_left = 0;
   int sb_q[$];

   function automatic int aval();
      return a_neg ? -a_mag : a_mag;
   endfunction
   function automatic int bval();
      return b_neg ? -b_mag : b_mag;
   endfunction

   task automatic m_clear_all();
      m_st = 0; a_mag = 0; b_mag = 0; a_cnt = 0; b_cnt = 0;
      a_neg = 0; b_neg = 0; m_ovf = 0; m_prod = 0;
   endtask

   task automatic m_digit(input int d, inout int mag, inout int cnt);
      if (cnt < MAXD && mag * 10 + d <= MAXMAG) begin
         mag = mag * 10 + d;
         cnt++;
      end else begin
         m_ovf = 1;
      end
   endtask

   task automatic model_edge(input bit r, input bit kv, input int k);
      if (r) begin
         if (m_st == 2) void'(sb_q.pop_back());
         m_clear_all();
      end else if (m_st == 2) begin
         m_left--;
         if (m_left == 0) begin
            m_st = 3;
            m_prod = aval() * bval();
         end
      end else if (kv) begin
         case (m_st)
            0: begin
               if (k <= 9) m_digit(k, a_mag, a_cnt);
               else if (k == 10) a_neg = ~a_neg;
               else if (k == 11) begin m_st = 1; b_mag = 0; b_neg = 0; b_cnt = 0; end
               else if (k == 12) begin a_mag = 0; a_neg = 0; a_cnt = 0; m_ovf = 0; end
               else if (k == 15) m_clear_all();
            end
            1: begin
               if (k <= 9) m_digit(k, b_mag, b_cnt);
               else if (k == 10) b_neg = ~b_neg;
               else if (k == 12) begin b_mag = 0; b_neg = 0; b_cnt = 0; m_ovf = 0; end
               else if (k == 13) begin
                  m_st = 2;
                  m_left = W;
                  sb_q.push_back(aval() * bval());
               end
               else if (k == 15) m_clear_all();
            end
            default: begin
               if (k <= 9) begin m_clear_all(); m_digit(k, a_mag, a_cnt); end
               else if (k == 15) m_clear_all();
            end
         endcase
      end
   endtask

   task automatic check_all();
      int sel;
      sel = (m_st == 0) ? aval() : (m_st == 3) ? m_prod : bval();
      chk("a_val", a_val, aval());
      chk("b_val", b_val, bval());
      chk("product", product, m_prod);
      chk("display_value", display_value, (sel < 0) ? -sel : sel);
      chk("display_neg", display_neg, (sel < 0) ? 1 : 0);
      chk("busy", busy, (m_st == 2) ? 1 : 0);
      chk("overflow", overflow, m_ovf);
   endtask

   // Called at a falling edge; drives one rising edge and checks after it.
   task automatic tick(input bit r, input bit kv, input logic [3:0] k);
      rst = r; key_valid = kv; key_code = k;
      @(negedge clk);
      rst = 1'b0; key_valid = 1'b0;
      model_edge(r, kv, int'(k));
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 4'h0);
   endtask

   task automatic keys(input string s);
      byte c;
      logic [3:0] k;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         if (c >= "0" && c <= "9") k = 4'(c - "0");
         else k = 4'(c - "A" + 10);
         tick(0, 1, k);
      end
   endtask

   // Scoreboard monitor: pops an expected product on every done pulse.
   int busy_run = 0;
   int mon_exp;
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_done actual product=%0d required no done", product);
         end else begin
            mon_exp = sb_q.pop_front();
            chk("sb_product", product, mon_exp);
            chk("sb_display_value", display_value, (mon_exp < 0) ? -mon_exp : mon_exp);
            chk("sb_display_neg", display_neg, (mon_exp < 0) ? 1 : 0);
            chk("sb_busy_cycles", busy_run, W);
         end
         busy_run = 0;
      end else if (busy) begin
         busy_run++;
      end else begin
         busy_run = 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      // reset together with a key: key discarded
      tick(1, 1, 4'h5);
      chk("reset_a_val", a_val, 0);
      chk("reset_done", done, 0);
      chk("reset_display", display_value, 0);

      keys("12B34D");
      idle(W + 1);
      chk("tp_408_product", product, 408);
      chk("tp_408_display", display_value, 408);

      keys("FA127B127D");
      idle(W + 1);
      chk("tp_neg_a_val", a_val, -127);
      chk("tp_neg_product", product, -16129);
      chk("tp_neg_display", display_value, 16129);
      chk("tp_neg_sign", display_neg, 1);

      keys("F128");
      chk("tp_ovf_a", a_val, 12);
      chk("tp_ovf_flag", overflow, 1);
      keys("C");
      chk("tp_clr_ovf", overflow, 0);
      keys("1234");
      chk("tp_maxd_a", a_val, 123);
      chk("tp_maxd_ovf", overflow, 1);

      keys("B3D");
      keys("F5DA");
      idle(W);
      chk("mult_keys_ignored_product", product, 369);

      keys("F12B3D");
      idle(3);
      tick(1, 0, 4'h0);
      chk("abort_busy", busy, 0);
      chk("abort_product", product, 0);
      idle(W + 3);
      chk("abort_b_val", b_val, 0);

      keys("0BA5D");
      idle(W + 1);
      chk("zero_product", product, 0);
      chk("zero_neg", display_neg, 0);
      keys("7");
      chk("show_digit_a", a_val, 7);
      chk("show_digit_b", b_val, 0);
      chk("show_digit_display", display_value, 7);

      for (int i = 0; i < 2500; i++) begin
         bit r, kv;
         logic [3:0] k;
         r  = ($urandom_range(0, 299) == 0);
         kv = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) < 6) k = 4'($urandom_range(0, 9));
         else k = 4'($urandom_range(10, 15));
         tick(r, kv, k);
      end

      idle(W + 3);
      chk("sb_drain", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
